// File: rtl/olp_pkg.sv
// rtl/olp_pkg.sv - size/pass codes, FSM encoding and helpers shared by the candidate writer
package olp_pkg;

  localparam int COORD_W_DEF = 9;
  localparam int ADDR_W_DEF  = 6;

  localparam logic [1:0] SIZE_23  = 2'd0;
  localparam logic [1:0] SIZE_19  = 2'd1;
  localparam logic [1:0] SIZE_17  = 2'd2;
  localparam logic [1:0] SIZE_INV = 2'd3;

  localparam logic [1:0] PASS_FACE    = 2'b11;
  localparam logic [1:0] PASS_PARTIAL = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_CLOSE, ST_DONE} olp_state_e;
  typedef enum logic [1:0] {DST_NONE, DST_FF19, DST_FF17, DST_FACE} olp_dest_e;

  // A partial pass at scale N feeds the next smaller scale; the smallest scale has nowhere to go.
  function automatic olp_dest_e route(input logic [1:0] pass, input logic [1:0] size);
    olp_dest_e d;
    d = DST_NONE;
    if (size != SIZE_INV) begin
      if (pass == PASS_FACE) begin
        d = DST_FACE;
      end else if (pass == PASS_PARTIAL) begin
        case (size)
          SIZE_23: d = DST_FF19;
          SIZE_19: d = DST_FF17;
          SIZE_17: d = DST_NONE;
          default: d = DST_NONE;
        endcase
      end
    end
    return d;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/olp_candidate_writer_if.sv
// rtl/olp_candidate_writer_if.sv - result/FIFO/face bus of the candidate writer
// OLP_CAND_STATS_EN adds the oCand_cnt/oDrop_cnt counters.
interface olp_candidate_writer_if import olp_pkg::*; #(parameter int COORD_W = COORD_W_DEF);

  logic                   iFrame_start;
  logic                   iFrame_end;
  logic                   iResult_valid;
  logic [1:0]             iPass;
  logic [1:0]             iSize;
  logic [COORD_W-1:0]     iX;
  logic [COORD_W-1:0]     iY;
  logic                   iRd_FF_19x19;
  logic                   iRd_FF_17x17;
  logic [2*COORD_W-1:0]   oData_FF_19x19;
  logic [2*COORD_W-1:0]   oData_FF_17x17;
  logic                   oEmpty_FF_19x19;
  logic                   oEmpty_FF_17x17;
  logic                   oFull_FF_19x19;
  logic                   oFull_FF_17x17;
  logic                   oFace_valid;
  logic [COORD_W-1:0]     oFace_x;
  logic [COORD_W-1:0]     oFace_y;
  logic [1:0]             oFace_size;
  logic                   oOverflow;
  logic                   oBusy;
  logic                   oFrame_done;
`ifdef OLP_CAND_STATS_EN
  logic [15:0]            oCand_cnt;
  logic [15:0]            oDrop_cnt;
`endif

  modport master (
    output iFrame_start, iFrame_end, iResult_valid, iPass, iSize, iX, iY,
    output iRd_FF_19x19, iRd_FF_17x17,
    input  oData_FF_19x19, oData_FF_17x17, oEmpty_FF_19x19, oEmpty_FF_17x17,
    input  oFull_FF_19x19, oFull_FF_17x17, oFace_valid, oFace_x, oFace_y, oFace_size,
    input  oOverflow, oBusy, oFrame_done
`ifdef OLP_CAND_STATS_EN
    , input oCand_cnt, oDrop_cnt
`endif
  );

  modport slave (
    input  iFrame_start, iFrame_end, iResult_valid, iPass, iSize, iX, iY,
    input  iRd_FF_19x19, iRd_FF_17x17,
    output oData_FF_19x19, oData_FF_17x17, oEmpty_FF_19x19, oEmpty_FF_17x17,
    output oFull_FF_19x19, oFull_FF_17x17, oFace_valid, oFace_x, oFace_y, oFace_size,
    output oOverflow, oBusy, oFrame_done
`ifdef OLP_CAND_STATS_EN
    , output oCand_cnt, oDrop_cnt
`endif
  );

endinterface

// File: rtl/olp_cand_fifo.sv
// rtl/olp_cand_fifo.sv - synchronous candidate FIFO with registered read data and flush
module olp_cand_fifo import olp_pkg::*; #(
  parameter int DATA_W = 2*COORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  output logic              push_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_pop;
  logic              do_push;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    do_pop    = pop && !empty && !flush;
    do_push   = push && !flush && (!full || do_pop);
    push_drop = push && !flush && full && !do_pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
  end

  assign pop_data = rd_data_q;

endmodule

// File: rtl/olp_candidate_writer.sv
// rtl/olp_candidate_writer.sv - routes classifier results into the 19x19/17x17 candidate FIFOs
// and reports faces; OLP_CAND_STATS_EN adds accepted/dropped push counters.
module olp_candidate_writer import olp_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  olp_candidate_writer_if.slave bus
);

  olp_state_e         state_q, state_d;
  logic               stg_vld_q, stg_vld_d;
  logic [1:0]         stg_pass_q, stg_pass_d;
  logic [1:0]         stg_size_q, stg_size_d;
  logic [COORD_W-1:0] stg_x_q, stg_x_d;
  logic [COORD_W-1:0] stg_y_q, stg_y_d;
  logic               face_vld_q, face_vld_d;
  logic [COORD_W-1:0] face_x_q, face_x_d;
  logic [COORD_W-1:0] face_y_q, face_y_d;
  logic [1:0]         face_size_q, face_size_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start;
  logic               sample;
  olp_dest_e          dest;
  logic               push19, push17;
  logic               drop19, drop17;

  always_comb begin
    start  = bus.iFrame_start;
    // The result arriving alongside iFrame_end is still taken while ACTIVE.
    sample = bus.iResult_valid && (state_q == ST_ACTIVE) && !start;
    dest   = route(stg_pass_q, stg_size_q);
    push19 = stg_vld_q && (dest == DST_FF19);
    push17 = stg_vld_q && (dest == DST_FF17);

    state_d = state_q;
    if (start) begin
      state_d = ST_ACTIVE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_ACTIVE: if (bus.iFrame_end) state_d = ST_CLOSE;
        ST_CLOSE:  state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
      endcase
    end

    stg_vld_d  = sample;
    stg_pass_d = sample ? bus.iPass : stg_pass_q;
    stg_size_d = sample ? bus.iSize : stg_size_q;
    stg_x_d    = sample ? bus.iX    : stg_x_q;
    stg_y_d    = sample ? bus.iY    : stg_y_q;

    face_vld_d  = stg_vld_q && (dest == DST_FACE) && !start;
    face_x_d    = face_vld_d ? stg_x_q    : face_x_q;
    face_y_d    = face_vld_d ? stg_y_q    : face_y_q;
    face_size_d = face_vld_d ? stg_size_q : face_size_q;

    ovf_d  = start ? 1'b0 : (ovf_q || drop19 || drop17);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_CLOSE) && !start;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      stg_vld_q   <= 1'b0;
      stg_pass_q  <= '0;
      stg_size_q  <= '0;
      stg_x_q     <= '0;
      stg_y_q     <= '0;
      face_vld_q  <= 1'b0;
      face_x_q    <= '0;
      face_y_q    <= '0;
      face_size_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stg_vld_q   <= stg_vld_d;
      stg_pass_q  <= stg_pass_d;
      stg_size_q  <= stg_size_d;
      stg_x_q     <= stg_x_d;
      stg_y_q     <= stg_y_d;
      face_vld_q  <= face_vld_d;
      face_x_q    <= face_x_d;
      face_y_q    <= face_y_d;
      face_size_q <= face_size_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  olp_cand_fifo #(.DATA_W(2*COORD_W), .ADDR_W(ADDR_W)) u_ff_19x19 (
    .clk       (iClk),
    .rst_n     (iReset_n),
    .flush     (start),
    .push      (push19),
    .push_data ({stg_y_q, stg_x_q}),
    .pop       (bus.iRd_FF_19x19),
    .pop_data  (bus.oData_FF_19x19),
    .empty     (bus.oEmpty_FF_19x19),
    .full      (bus.oFull_FF_19x19),
    .push_drop (drop19)
  );

  olp_cand_fifo #(.DATA_W(2*COORD_W), .ADDR_W(ADDR_W)) u_ff_17x17 (
    .clk       (iClk),
    .rst_n     (iReset_n),
    .flush     (start),
    .push      (push17),
    .push_data ({stg_y_q, stg_x_q}),
    .pop       (bus.iRd_FF_17x17),
    .pop_data  (bus.oData_FF_17x17),
    .empty     (bus.oEmpty_FF_17x17),
    .full      (bus.oFull_FF_17x17),
    .push_drop (drop17)
  );

  assign bus.oFace_valid = face_vld_q;
  assign bus.oFace_x     = face_x_q;
  assign bus.oFace_y     = face_y_q;
  assign bus.oFace_size  = face_size_q;
  assign bus.oOverflow   = ovf_q;
  assign bus.oBusy       = busy_q;
  assign bus.oFrame_done = done_q;

`ifdef OLP_CAND_STATS_EN
  logic [15:0] cand_cnt_q, cand_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]  ok_inc, drop_inc;

  always_comb begin
    ok_inc     = {1'b0, push19 && !drop19 && !start} + {1'b0, push17 && !drop17 && !start};
    drop_inc   = {1'b0, drop19} + {1'b0, drop17};
    cand_cnt_d = start ? 16'd0 : sat_add16(cand_cnt_q, ok_inc);
    drop_cnt_d = start ? 16'd0 : sat_add16(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cand_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      cand_cnt_q <= cand_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.oCand_cnt = cand_cnt_q;
  assign bus.oDrop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_olp_candidate_writer.sv
// tb/tb_olp_candidate_writer.sv - scoreboard bench for olp_candidate_writer
module tb_olp_candidate_writer;
  import olp_pkg::*;

  localparam int CW = 9;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [1:0]    size;
  } face_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  olp_candidate_writer_if #(.COORD_W(CW)) bus ();

  olp_candidate_writer #(.COORD_W(CW), .ADDR_W(6)) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  face_t         face_q[$];
  logic [17:0]   exp19[$];
  logic [17:0]   exp17[$];
  logic          rd19_edge = 1'b0;
  logic          rd17_edge = 1'b0;
  logic [17:0]   last19 = '0;
  logic [17:0]   last17 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rd19_edge <= bus.iRd_FF_19x19;
    rd17_edge <= bus.iRd_FF_17x17;
  end

  always @(negedge clk) begin
    face_t f;
    if (bus.oFace_valid) begin
      if (face_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL face_unexpected: got x=%0d y=%0d size=%0d expected none",
                 bus.oFace_x, bus.oFace_y, bus.oFace_size);
      end else begin
        f = face_q.pop_front();
        chk("face_x", 32'(bus.oFace_x), 32'(f.x));
        chk("face_y", 32'(bus.oFace_y), 32'(f.y));
        chk("face_size", 32'(bus.oFace_size), 32'(f.size));
      end
    end
    if (rd19_edge) begin
      if (exp19.size() > 0) chk("pop19_data", 32'(bus.oData_FF_19x19), 32'(exp19.pop_front()));
      else                  chk("pop19_hold", 32'(bus.oData_FF_19x19), 32'(last19));
    end
    if (rd17_edge) begin
      if (exp17.size() > 0) chk("pop17_data", 32'(bus.oData_FF_17x17), 32'(exp17.pop_front()));
      else                  chk("pop17_hold", 32'(bus.oData_FF_17x17), 32'(last17));
    end
    last19 = bus.oData_FF_19x19;
    last17 = bus.oData_FF_17x17;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dest: 0 discard, 1 19x19 FIFO, 2 17x17 FIFO, 3 face report
  task automatic send(input logic [1:0] pass, input logic [1:0] size,
                      input logic [CW-1:0] x, input logic [CW-1:0] y, input int dest);
    face_t f;
    bus.iResult_valid = 1'b1;
    bus.iPass = pass;
    bus.iSize = size;
    bus.iX = x;
    bus.iY = y;
    case (dest)
      1: exp19.push_back({y, x});
      2: exp17.push_back({y, x});
      3: begin
        f.x = x; f.y = y; f.size = size;
        face_q.push_back(f);
      end
      default: ;
    endcase
    tick();
    bus.iResult_valid = 1'b0;
  endtask

  task automatic pop19();
    bus.iRd_FF_19x19 = 1'b1;
    tick();
    bus.iRd_FF_19x19 = 1'b0;
  endtask

  task automatic pop17();
    bus.iRd_FF_17x17 = 1'b1;
    tick();
    bus.iRd_FF_17x17 = 1'b0;
  endtask

  task automatic frame_start();
    bus.iFrame_start = 1'b1;
    tick();
    bus.iFrame_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.iFrame_start = 0; bus.iFrame_end = 0; bus.iResult_valid = 0;
    bus.iPass = 0; bus.iSize = 0; bus.iX = 0; bus.iY = 0;
    bus.iRd_FF_19x19 = 0; bus.iRd_FF_17x17 = 0;
    tick(); tick();

    chk("rst_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("rst_empty17", 32'(bus.oEmpty_FF_17x17), 1);
    chk("rst_full19", 32'(bus.oFull_FF_19x19), 0);
    chk("rst_busy", 32'(bus.oBusy), 0);
    chk("rst_overflow", 32'(bus.oOverflow), 0);
    chk("rst_done", 32'(bus.oFrame_done), 0);
    chk("rst_data19", 32'(bus.oData_FF_19x19), 0);
    rst_n = 1'b1;
    tick();

    frame_start();
    chk("start_busy", 32'(bus.oBusy), 1);

    send(2'b01, 2'd0, 9'd5, 9'd7, 1);
    chk("e0_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    tick();
    chk("e1_empty19", 32'(bus.oEmpty_FF_19x19), 0);
    chk("e1_empty17", 32'(bus.oEmpty_FF_17x17), 1);
    pop19();
    chk("pop_empty19", 32'(bus.oEmpty_FF_19x19), 1);

    send(2'b01, 2'd1, 9'd3, 9'd4, 2);
    tick();
    chk("s1_empty17", 32'(bus.oEmpty_FF_17x17), 0);
    chk("s1_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    pop17();

    send(2'b01, 2'd2, 9'd8, 9'd8, 0);
    send(2'b10, 2'd0, 9'd8, 9'd8, 0);
    send(2'b00, 2'd1, 9'd8, 9'd8, 0);
    send(2'b01, 2'd3, 9'd8, 9'd8, 0);
    send(2'b11, 2'd3, 9'd9, 9'd9, 0);
    tick();
    chk("rej_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("rej_empty17", 32'(bus.oEmpty_FF_17x17), 1);

    send(2'b11, 2'd2, 9'd10, 9'd20, 3);
    tick(); tick();
    chk("face_no_write19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("face_no_write17", 32'(bus.oEmpty_FF_17x17), 1);

    send(2'b01, 2'd0, 9'd1, 9'd2, 1);
    send(2'b11, 2'd0, 9'd3, 9'd4, 3);
    send(2'b01, 2'd0, 9'd5, 9'd6, 1);
    tick();
    pop19();
    pop19();

    for (int i = 0; i < 65; i++) send(2'b01, 2'd0, 9'(i), 9'(i + 64), (i < 64) ? 1 : 0);
    tick();
    chk("fill_full19", 32'(bus.oFull_FF_19x19), 1);
    chk("fill_overflow", 32'(bus.oOverflow), 1);
    chk("fill_empty19", 32'(bus.oEmpty_FF_19x19), 0);

    send(2'b01, 2'd0, 9'd100, 9'd200, 1);
    pop19();
    chk("pushpop_full19", 32'(bus.oFull_FF_19x19), 1);

    bus.iRd_FF_19x19 = 1'b1;
    repeat (64) tick();
    bus.iRd_FF_19x19 = 1'b0;
    chk("drain_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("drain_full19", 32'(bus.oFull_FF_19x19), 0);
    pop19();
    chk("extra_pop_empty19", 32'(bus.oEmpty_FF_19x19), 1);
`ifdef OLP_CAND_STATS_EN
    chk("stats_drop", 32'(bus.oDrop_cnt), 1);
    chk("stats_cand", 32'(bus.oCand_cnt), 69);
`endif

    bus.iResult_valid = 1'b1; bus.iPass = 2'b01; bus.iSize = 2'd1;
    bus.iX = 9'd11; bus.iY = 9'd12; bus.iFrame_end = 1'b1;
    exp17.push_back({9'd12, 9'd11});
    tick();
    bus.iResult_valid = 1'b0; bus.iFrame_end = 1'b0;
    chk("end_e0_done", 32'(bus.oFrame_done), 0);
    chk("end_e0_busy", 32'(bus.oBusy), 1);
    chk("end_e0_empty17", 32'(bus.oEmpty_FF_17x17), 1);
    tick();
    chk("end_e1_empty17", 32'(bus.oEmpty_FF_17x17), 0);
    chk("end_e1_done", 32'(bus.oFrame_done), 1);
    tick();
    chk("end_e2_done", 32'(bus.oFrame_done), 0);
    chk("end_e2_busy", 32'(bus.oBusy), 0);
    send(2'b01, 2'd0, 9'd1, 9'd1, 0);
    tick();
    chk("idle_ignore19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("idle_overflow_sticky", 32'(bus.oOverflow), 1);
    pop17();

    frame_start();
    chk("f2_overflow", 32'(bus.oOverflow), 0);
    chk("f2_busy", 32'(bus.oBusy), 1);
    send(2'b01, 2'd0, 9'd33, 9'd44, 1);
    tick();
    chk("f2_empty19", 32'(bus.oEmpty_FF_19x19), 0);
    rst_n = 1'b0;
    exp19.delete();
    #1;
    chk("arst_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    chk("arst_busy", 32'(bus.oBusy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    frame_start();
    chk("f3_empty19", 32'(bus.oEmpty_FF_19x19), 1);
    send(2'b01, 2'd0, 9'd2, 9'd3, 1);
    tick();
    pop19();
    tick(); tick();

    chk("end_face_q", face_q.size(), 0);
    chk("end_exp19", exp19.size(), 0);
    chk("end_exp17", exp17.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
